// File: rtl/noc_fifo_endpoint.sv
// Router-clock side of the PM <-> NoC asynchronous FIFO link: owns the pm_in
// storage written from the NoC and drains the PM-owned pm_out FIFO onto a registered rx port.
module noc_fifo_endpoint #(
  parameter int NOC_ASYNC_FIFO_PACKET_SIZE = 32,
  parameter int NOC_ASYNC_FIFO_AWIDTH      = 3,
  parameter int SYNC_STAGES                = 2
) (
  input  logic                                  clk_noc_i,
  input  logic                                  reset_noc_i,
  input  logic                                  tx_valid_i,
  output logic                                  tx_ready_o,
  input  logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] tx_data_i,
  output logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] noc_fifo_pm_in_data_o,
  input  logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_in_raddr_i,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_in_waddr_o,
  input  logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] noc_fifo_pm_out_data_i,
  output logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_out_raddr_o,
  input  logic [NOC_ASYNC_FIFO_AWIDTH:0]        noc_fifo_pm_out_waddr_i,
  output logic                                  rx_valid_o,
  input  logic                                  rx_ready_i,
  output logic [NOC_ASYNC_FIFO_PACKET_SIZE-1:0] rx_data_o
);

  localparam int P     = NOC_ASYNC_FIFO_PACKET_SIZE;
  localparam int A     = NOC_ASYNC_FIFO_AWIDTH;
  localparam int DEPTH = 1 << A;

  function automatic logic [A:0] bin2gray(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Pointer synchronizers: index 0 samples the async input, last index is used.
  logic [SYNC_STAGES-1:0][A:0] rsync_pipe, wsync_pipe;

  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      rsync_pipe <= '0;
      wsync_pipe <= '0;
    end else begin
      rsync_pipe <= {rsync_pipe[SYNC_STAGES-2:0], noc_fifo_pm_in_raddr_i};
      wsync_pipe <= {wsync_pipe[SYNC_STAGES-2:0], noc_fifo_pm_out_waddr_i};
    end
  end

  // ---------------- write side (pm_in) ----------------
  logic [A:0]   wbin, wbin_nxt, wgray, rsync;
  logic         full, tx_fire;
  logic [A-1:0] pm_rd_idx;
  logic [P-1:0] mem [DEPTH];

  assign rsync    = rsync_pipe[SYNC_STAGES-1];
  assign full     = (wgray == {~rsync[A:A-1], rsync[A-2:0]});
  assign tx_ready_o = ~full & ~reset_noc_i;
  assign tx_fire  = tx_valid_i & tx_ready_o;
  assign wbin_nxt = wbin + (A+1)'(1);

  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      wbin  <= '0;
      wgray <= '0;
    end else if (tx_fire) begin
      wbin  <= wbin_nxt;
      wgray <= bin2gray(wbin_nxt);
    end
  end

  always_ff @(posedge clk_noc_i) begin
    if (tx_fire) mem[wbin[A-1:0]] <= tx_data_i;
  end

  // Raw PM pointer is fine here: a slot is not rewritten until the synced
  // PM pointer has moved past it, so the addressed entry is stable.
  assign pm_rd_idx              = A'(gray2bin(noc_fifo_pm_in_raddr_i));
  assign noc_fifo_pm_in_data_o  = mem[pm_rd_idx];
  assign noc_fifo_pm_in_waddr_o = wgray;

  // ---------------- read side (pm_out) ----------------
  logic [A:0] rbin, rbin_nxt, rgray, wsync;
  logic       empty, load;

  assign wsync    = wsync_pipe[SYNC_STAGES-1];
  assign empty    = (rgray == wsync);
  assign load     = ~empty & (~rx_valid_o | rx_ready_i);
  assign rbin_nxt = rbin + (A+1)'(1);

  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      rbin       <= '0;
      rgray      <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
    end else if (load) begin
      rx_data_o  <= noc_fifo_pm_out_data_i;
      rx_valid_o <= 1'b1;
      rbin       <= rbin_nxt;
      rgray      <= bin2gray(rbin_nxt);
    end else if (rx_ready_i & rx_valid_o) begin
      rx_valid_o <= 1'b0;
    end
  end

  assign noc_fifo_pm_out_raddr_o = rgray;

endmodule

// File: tb/tb_noc_fifo_endpoint.sv
// Bench for noc_fifo_endpoint: per-cycle occupancy/queue model on the negedge,
// behavioural PM on both FIFOs, plus directed literal checks.
module tb_noc_fifo_endpoint;
  localparam int P = 8;
  localparam int A = 3;
  localparam int S = 2;
  localparam int N = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_valid;
  logic         tx_ready;
  logic [P-1:0] tx_data;
  logic [P-1:0] pm_in_data;
  logic [A:0]   raddr_i;
  logic [A:0]   waddr_o;
  logic [P-1:0] pm_out_data;
  logic [A:0]   raddr_o;
  logic [A:0]   waddr_i;
  logic         rx_valid;
  logic         rx_ready;
  logic [P-1:0] rx_data;

  always #5 clk = ~clk;

  noc_fifo_endpoint #(
    .NOC_ASYNC_FIFO_PACKET_SIZE(P),
    .NOC_ASYNC_FIFO_AWIDTH(A),
    .SYNC_STAGES(S)
  ) dut (
    .clk_noc_i(clk),
    .reset_noc_i(rst),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .tx_data_i(tx_data),
    .noc_fifo_pm_in_data_o(pm_in_data),
    .noc_fifo_pm_in_raddr_i(raddr_i),
    .noc_fifo_pm_in_waddr_o(waddr_o),
    .noc_fifo_pm_out_data_i(pm_out_data),
    .noc_fifo_pm_out_raddr_o(raddr_o),
    .noc_fifo_pm_out_waddr_i(waddr_i),
    .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready),
    .rx_data_o(rx_data)
  );

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PM-owned pm_out storage, read combinationally at our read pointer
  logic [P-1:0] pm_mem [8];
  assign pm_out_data = pm_mem[3'(g2b(raddr_o))];

  logic [P-1:0] tx_q[$];   // accepted NoC packets not yet read by the PM
  logic [P-1:0] pm_q[$];   // PM-written packets not yet loaded into rx
  logic [3:0]   pm_rd, pm_wbin;
  int           pm_rd_cnt, pm_wr_cnt, n_tx_acc, n_rx_got;
  logic         pm_rd_en, pm_wr_en, tx_en, rx_en;

  // ---------------- model + compare (negedge) ----------------
  logic       mon_on = 1'b0;
  logic       prev_rst;
  logic [3:0] prev_w, prev_r;
  logic [3:0] m_wcnt, m_rcnt, occ;
  logic       m_rx_valid, exp_ready, m_empty;
  logic [P-1:0] m_rx_data;
  logic [3:0] rhist [S];
  logic [3:0] whist [S];

  task automatic model_reset();
    m_wcnt = '0;
    m_rcnt = '0;
    m_rx_valid = 1'b0;
    m_rx_data = '0;
    tx_q.delete();
    for (int i = 0; i < S; i++) begin
      rhist[i] = '0;
      whist[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (!mon_on) begin
      if (rst) begin
        model_reset();
        mon_on = 1'b1;
        prev_rst = 1'b1;
      end
    end else begin
      // pm_in holds (written - PM pointer seen S edges ago); full at 8
      occ = m_wcnt - g2b(rhist[S-1]);
      exp_ready = !rst && (occ != 4'd8);
      chk("tx_ready", 32'(tx_ready), 32'(exp_ready));
      chk("pm_in_waddr", 32'(waddr_o), 32'(b2g(m_wcnt)));
      chk("pm_out_raddr", 32'(raddr_o), 32'(b2g(m_rcnt)));
      chk("rx_valid", 32'(rx_valid), 32'(m_rx_valid));
      chk("rx_data", 32'(rx_data), 32'(m_rx_data));
      if (!rst && !prev_rst) begin
        chk("waddr_gray_step", 32'($countones(waddr_o ^ prev_w) <= 1), 32'(1));
        chk("raddr_gray_step", 32'($countones(raddr_o ^ prev_r) <= 1), 32'(1));
      end
      if (rst) model_reset();
      else begin
        if (tx_valid && exp_ready) begin
          tx_q.push_back(tx_data);
          m_wcnt++;
          n_tx_acc++;
        end
        if (m_rx_valid && rx_ready) n_rx_got++;
        m_empty = (g2b(whist[S-1]) == m_rcnt);
        if (!m_empty && (!m_rx_valid || rx_ready)) begin
          if (pm_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_model_underflow: got load with no PM packet, expected none");
          end else m_rx_data = pm_q.pop_front();
          m_rx_valid = 1'b1;
          m_rcnt++;
        end else if (m_rx_valid && rx_ready) m_rx_valid = 1'b0;
        for (int i = S - 1; i > 0; i--) begin
          rhist[i] = rhist[i-1];
          whist[i] = whist[i-1];
        end
        rhist[0] = raddr_i;
        whist[0] = waddr_i;
      end
      prev_w = waddr_o;
      prev_r = raddr_o;
      prev_rst = rst;
    end
  end

  // ---------------- stimulus: one cycle + behavioural PM ----------------
  task automatic step();
    logic [3:0] pm_occ;
    @(posedge clk);
    #1;
    if (pm_rd_en && (g2b(waddr_o) != pm_rd) && ($urandom_range(0, 2) != 0)) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pm_in_underflow: got waddr ahead with no queued packet, expected none");
      end else chk("pm_in_data", 32'(pm_in_data), 32'(tx_q.pop_front()));
      pm_rd++;
      raddr_i = b2g(pm_rd);
      pm_rd_cnt++;
    end
    pm_occ = pm_wbin - g2b(raddr_o);
    if (pm_wr_en && pm_wr_cnt < N && pm_occ != 4'd8 && ($urandom_range(0, 3) != 0)) begin
      pm_mem[pm_wbin[2:0]] = 8'h80 + 8'(pm_wr_cnt);
      pm_q.push_back(8'h80 + 8'(pm_wr_cnt));
      pm_wbin++;
      waddr_i = b2g(pm_wbin);
      pm_wr_cnt++;
    end
    if (tx_en) begin
      tx_valid = (n_tx_acc < N) && ($urandom_range(0, 3) != 0);
      tx_data  = 8'h10 + 8'(n_tx_acc);
    end
    if (rx_en) rx_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    raddr_i = '0;
    waddr_i = '0;
    pm_rd = '0;
    pm_wbin = '0;
    pm_q.delete();
    n_tx_acc = 0;
    n_rx_got = 0;
    pm_rd_cnt = 0;
    pm_wr_cnt = 0;
    repeat (cycles) step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    pm_rd_en = 1'b0; pm_wr_en = 1'b0; tx_en = 1'b0; rx_en = 1'b0;
    tx_data = '0;
    for (int i = 0; i < 8; i++) pm_mem[i] = '0;
    rst = 1'b1; tx_valid = 1'b1; rx_ready = 1'b1;
    raddr_i = 4'b0110; waddr_i = 4'b0011;
    pm_rd = '0; pm_wbin = '0;
    n_tx_acc = 0; n_rx_got = 0; pm_rd_cnt = 0; pm_wr_cnt = 0;
    repeat (2) step();
    chk("rst_tx_ready", 32'(tx_ready), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_waddr", 32'(waddr_o), 32'(0));
    chk("rst_raddr", 32'(raddr_o), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    do_reset(1);
    chk("post_rst_tx_ready", 32'(tx_ready), 32'(1));

    // single write
    tx_data = 8'h5A; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("single_wr_waddr", 32'(waddr_o), 32'(4'b0001));
    chk("single_wr_data", 32'(pm_in_data), 32'(8'h5A));

    // fill to 8, then PM frees one slot
    tx_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tx_data = 8'h60 + 8'(i);
      step();
    end
    tx_valid = 1'b0;
    chk("fill_tx_ready", 32'(tx_ready), 32'(0));
    chk("fill_waddr", 32'(waddr_o), 32'(4'b1100));
    raddr_i = 4'b0001;
    step();
    chk("release_1cyc_ready", 32'(tx_ready), 32'(0));
    step();
    chk("release_2cyc_ready", 32'(tx_ready), 32'(1));

    // single read with first-data latency
    pm_mem[0] = 8'hC3; pm_q.push_back(8'hC3); pm_wbin = 4'd1;
    waddr_i = 4'b0001; rx_ready = 1'b0;
    step(); step();
    chk("rd_lat2_valid", 32'(rx_valid), 32'(0));
    step();
    chk("rd_lat3_valid", 32'(rx_valid), 32'(1));
    chk("rd_lat3_data", 32'(rx_data), 32'(8'hC3));
    chk("rd_raddr", 32'(raddr_o), 32'(4'b0001));
    step(); step();
    chk("rd_hold_valid", 32'(rx_valid), 32'(1));
    chk("rd_hold_data", 32'(rx_data), 32'(8'hC3));
    rx_ready = 1'b1;
    step();
    chk("rd_consume_valid", 32'(rx_valid), 32'(0));

    // streaming both directions with random stalls
    do_reset(2);
    pm_rd_en = 1'b1; pm_wr_en = 1'b1; tx_en = 1'b1; rx_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (pm_rd_cnt >= N && pm_wr_cnt >= N && n_rx_got >= N && n_tx_acc >= N) break;
      step();
    end
    pm_rd_en = 1'b0; pm_wr_en = 1'b0; tx_en = 1'b0; rx_en = 1'b0;
    tx_valid = 1'b0; rx_ready = 1'b0;
    chk("stream_tx_accepted", 32'(n_tx_acc), 32'(N));
    chk("stream_pm_read", 32'(pm_rd_cnt), 32'(N));
    chk("stream_pm_written", 32'(pm_wr_cnt), 32'(N));
    chk("stream_rx_got", 32'(n_rx_got), 32'(N));
    step();
    chk("stream_end_waddr", 32'(waddr_o), 32'(4'b1100));
    chk("stream_end_raddr", 32'(raddr_o), 32'(4'b1100));

    // buffer 5 each way, then reset mid-operation
    for (int k = 0; k < 5; k++) begin
      tx_valid = 1'b1; tx_data = 8'hA0 + 8'(k);
      pm_mem[pm_wbin[2:0]] = 8'hB0 + 8'(k);
      pm_q.push_back(8'hB0 + 8'(k));
      pm_wbin++;
      waddr_i = b2g(pm_wbin);
      step();
    end
    tx_valid = 1'b0;
    repeat (4) step();
    chk("buf_waddr", 32'(waddr_o), 32'(4'b1011));
    chk("buf_raddr", 32'(raddr_o), 32'(4'b1101));
    chk("buf_rx_valid", 32'(rx_valid), 32'(1));
    chk("buf_rx_data", 32'(rx_data), 32'(8'hB0));
    do_reset(1);
    chk("midrst_waddr", 32'(waddr_o), 32'(0));
    chk("midrst_raddr", 32'(raddr_o), 32'(0));
    chk("midrst_rx_valid", 32'(rx_valid), 32'(0));
    chk("midrst_tx_ready", 32'(tx_ready), 32'(1));

    tx_valid = 1'b1; tx_data = 8'hE1;
    pm_mem[0] = 8'hE2; pm_q.push_back(8'hE2); pm_wbin = 4'd1;
    waddr_i = 4'b0001;
    step();
    tx_valid = 1'b0;
    chk("after_rst_pm_in_data", 32'(pm_in_data), 32'(8'hE1));
    chk("after_rst_waddr", 32'(waddr_o), 32'(4'b0001));
    step();
    chk("after_rst_rx_early", 32'(rx_valid), 32'(0));
    step();
    chk("after_rst_rx_valid", 32'(rx_valid), 32'(1));
    chk("after_rst_rx_data", 32'(rx_data), 32'(8'hE2));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
